// File: rtl/data_utlb.sv
// data_utlb: registered 4-entry data micro-TLB for the MEM stage.
// Translates load/store virtual addresses, bypasses kseg0/kseg1 and
// refills from the shared JTLB over a req/ack handshake on a miss.
// Optional build macro UTLB_PERF_CNT_EN enables the perf_hit/perf_miss
// counters; without it both ports are tied to zero.
module data_utlb #(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_vaddr,
  input  logic [ASID_W-1:0] req_asid,
  input  logic              req_wmem,
  input  logic              flush,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_paddr,
  output logic              dataMiss,
  output logic              dataValid,
  output logic              dataDirty,
  output logic              resp_wmem,
  output logic              resp_cached,
  output logic              jtlb_req,
  output logic [18:0]       jtlb_vpn2,
  output logic [ASID_W-1:0] jtlb_asid,
  input  logic              jtlb_ack,
  input  logic              jtlb_found,
  input  logic [19:0]       jtlb_pfn0,
  input  logic [19:0]       jtlb_pfn1,
  input  logic [4:0]        jtlb_flags0,
  input  logic [4:0]        jtlb_flags1,
  input  logic              jtlb_g,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

  state_t              state;
  logic [ENTRIES-1:0]  e_valid;
  logic [ENTRIES-1:0]  e_g;
  logic [18:0]         e_vpn2   [ENTRIES];
  logic [ASID_W-1:0]   e_asid   [ENTRIES];
  logic [19:0]         e_pfn0   [ENTRIES];
  logic [19:0]         e_pfn1   [ENTRIES];
  logic [4:0]          e_flags0 [ENTRIES];
  logic [4:0]          e_flags1 [ENTRIES];
  logic [PW-1:0]       ptr;

  logic [31:0]         m_vaddr;
  logic [ASID_W-1:0]   m_asid;
  logic                m_wmem;
  logic                stale;

  logic                hit;
  logic [PW-1:0]       hit_idx;
  logic                unmapped;
  logic                accept;
  logic                idle_hit;
  logic                miss_start;
  logic                fill_we;
  logic [19:0]         sel_pfn;
  logic [4:0]          sel_flags;
  logic [19:0]         fill_pfn;
  logic [4:0]          fill_flags;

  // Fully associative lookup of the incoming request against all entries
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit && e_valid[i] && (e_vpn2[i] == req_vaddr[31:13]) &&
          (e_g[i] || (e_asid[i] == req_asid))) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Request classification, page selection and the combinational busy
  always_comb begin
    unmapped   = (req_vaddr[31:30] == 2'b10);
    accept     = req_valid && (state == S_IDLE);
    // a same-cycle flush makes the lookup see an empty array
    idle_hit   = hit && !flush;
    miss_start = accept && !unmapped && !idle_hit;
    busy       = (state != S_IDLE) || miss_start;
    sel_pfn    = req_vaddr[12] ? e_pfn1[hit_idx]   : e_pfn0[hit_idx];
    sel_flags  = req_vaddr[12] ? e_flags1[hit_idx] : e_flags0[hit_idx];
    fill_pfn   = m_vaddr[12] ? jtlb_pfn1 : jtlb_pfn0;
    fill_flags = m_vaddr[12] ? jtlb_flags1 : jtlb_flags0;
    fill_we    = (state == S_REFILL) && jtlb_ack && jtlb_found && !stale && !flush;
  end

  // Entry valid bits: flush clears all, a successful refill sets one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= '0;
    end else if (flush) begin
      e_valid <= '0;
    end else if (fill_we) begin
      e_valid[ptr] <= 1'b1;
    end
  end

  // Entry payload storage, written at the round-robin pointer
  always_ff @(posedge clk) begin
    if (fill_we) begin
      e_vpn2[ptr]   <= m_vaddr[31:13];
      e_asid[ptr]   <= m_asid;
      e_g[ptr]      <= jtlb_g;
      e_pfn0[ptr]   <= jtlb_pfn0;
      e_pfn1[ptr]   <= jtlb_pfn1;
      e_flags0[ptr] <= jtlb_flags0;
      e_flags1[ptr] <= jtlb_flags1;
    end
  end

  // Control FSM with registered response and JTLB request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      stale       <= 1'b0;
      m_vaddr     <= '0;
      m_asid      <= '0;
      m_wmem      <= 1'b0;
      jtlb_req    <= 1'b0;
      jtlb_vpn2   <= '0;
      jtlb_asid   <= '0;
      resp_valid  <= 1'b0;
      resp_paddr  <= '0;
      dataMiss    <= 1'b0;
      dataValid   <= 1'b0;
      dataDirty   <= 1'b0;
      resp_wmem   <= 1'b0;
      resp_cached <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (unmapped) begin
              resp_valid  <= 1'b1;
              resp_paddr  <= {3'b000, req_vaddr[28:0]};
              dataMiss    <= 1'b0;
              dataValid   <= 1'b1;
              dataDirty   <= 1'b1;
              resp_cached <= !req_vaddr[29];
              resp_wmem   <= req_wmem;
            end else if (idle_hit) begin
              resp_valid  <= 1'b1;
              resp_paddr  <= {sel_pfn, req_vaddr[11:0]};
              dataMiss    <= 1'b0;
              dataValid   <= sel_flags[0];
              dataDirty   <= sel_flags[1];
              resp_cached <= (sel_flags[4:2] == 3'b011);
              resp_wmem   <= req_wmem;
            end else begin
              m_vaddr   <= req_vaddr;
              m_asid    <= req_asid;
              m_wmem    <= req_wmem;
              jtlb_req  <= 1'b1;
              jtlb_vpn2 <= req_vaddr[31:13];
              jtlb_asid <= req_asid;
              stale     <= 1'b0;
              state     <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (jtlb_ack) begin
            if (stale || flush) begin
              // answer predates a flush: drop it and keep requesting
              stale <= 1'b0;
            end else begin
              jtlb_req   <= 1'b0;
              resp_valid <= 1'b1;
              resp_wmem  <= m_wmem;
              state      <= S_RESP;
              if (jtlb_found) begin
                resp_paddr  <= {fill_pfn, m_vaddr[11:0]};
                dataMiss    <= 1'b0;
                dataValid   <= fill_flags[0];
                dataDirty   <= fill_flags[1];
                resp_cached <= (fill_flags[4:2] == 3'b011);
                ptr         <= ptr + 1'b1;
              end else begin
                resp_paddr  <= '0;
                dataMiss    <= 1'b1;
                dataValid   <= 1'b0;
                dataDirty   <= 1'b0;
                resp_cached <= 1'b0;
              end
            end
          end else if (flush) begin
            stale <= 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UTLB_PERF_CNT_EN
  // Mapped-hit and refill-entry event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (accept && !unmapped && idle_hit) perf_hit <= perf_hit + 32'd1;
      if (miss_start) perf_miss <= perf_miss + 32'd1;
    end
  end
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
`endif

endmodule

// File: doc/data_utlb.md
Name: data_utlb

Overview:
- Registered 4-entry data micro-TLB in the MEM stage; translates load/store virtual addresses and produces the miss/valid/dirty flags consumed by the MEM-stage TLB exception detector.
- On a micro-TLB miss, runs a refill handshake against the shared joint TLB (JTLB).
- kseg0/kseg1 bypass translation entirely.

Parameters:
- ENTRIES, 4, number of micro-TLB entries (power of two, 2..8).
- ASID_W, 8, ASID width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  lookup request; accepted when req_valid && !busy
- req_vaddr  in  32  virtual address
- req_asid  in  ASID_W  current EntryHi ASID
- req_wmem  in  1  store access
- flush  in  1  invalidate all entries (TLBWI/TLBWR/ASID write)
- busy  out  1  refill in progress; request not accepted
- resp_valid  out  1  one-cycle result strobe
- resp_paddr  out  32  physical address
- dataMiss  out  1  no matching entry in JTLB
- dataValid  out  1  selected page V bit
- dataDirty  out  1  selected page D bit
- resp_wmem  out  1  registered req_wmem
- resp_cached  out  1  1 when C field == 3'b011
- jtlb_req  out  1  refill request, level
- jtlb_vpn2  out  19  vaddr[31:13] of missing page
- jtlb_asid  out  ASID_W  ASID of missing page
- jtlb_ack  in  1  one-cycle response strobe
- jtlb_found  in  1  JTLB hit, qualified by ack
- jtlb_pfn0  in  20  even-page PFN
- jtlb_pfn1  in  20  odd-page PFN
- jtlb_flags0  in  5  {C[2:0],D,V} for the even page
- jtlb_flags1  in  5  {C[2:0],D,V} for the odd page
- jtlb_g  in  1  global bit

Behaviour:
- Reset: all entries invalid; FSM=IDLE; round-robin pointer=0; all outputs 0.
- Entry fields: valid, vpn2, asid, g, pfn0/1, flags0/1.
- Entry matches when valid && vpn2==vaddr[31:13] && (g || asid==req_asid).
- req_vaddr[12] selects the odd page (1) or even page (0).
- Unmapped: vaddr[31:30]==2'b10 (kseg0/1).
  - resp_paddr = {3'b000, vaddr[28:0]}; dataMiss=0, dataValid=1, dataDirty=1.
  - resp_cached = !vaddr[29].
  - No entry lookup performed.
- IDLE, accepted request, hit or unmapped: resp_valid=1 next cycle with results.
  - Mapped-hit paddr = {pfn, vaddr[11:0]}.
  - Latency 1; back-to-back accepted every cycle.
- IDLE, accepted mapped request, no hit: latch vaddr/asid/wmem; busy=1 combinationally that cycle → REFILL.
- REFILL: jtlb_req=1 held until jtlb_ack.
  - On ack with found: write entry at the pointer, pointer+1 mod ENTRIES → RESP.
  - On ack with !found: → RESP with dataMiss=1, dataValid=0, dataDirty=0, paddr=0.
- RESP: one cycle; resp_valid=1.
  - Found case: results taken from the just-written entry.
  - busy=1 during RESP; → IDLE.
  - Miss-to-result latency = JTLB ack latency + 2.
- flush: clears all valid bits the same edge.
  - flush with an accepted request in the same cycle: lookup sees an empty array → refill.
  - flush in REFILL: the ack is consumed without writing; re-request with the same vpn2 next cycle.
  - flush in RESP: the result is still issued.
- V=0 or D=0 pages are cached normally; exception decision is downstream, no special handling here.
- rst mid-refill: jtlb_req drops immediately; the pending lookup is lost.
- Requests while busy are ignored (not queued).

Optional Feature:
- UTLB_PERF_CNT_EN: adds outputs perf_hit[31:0] and perf_miss[31:0].
  - perf_hit increments on each mapped micro-TLB hit.
  - perf_miss increments on each entry to REFILL (not on flush re-requests).
  - Both wrap at 2^32 and clear on rst.
- Without the macro: ports exist, tied to 0, no counter logic.

Test Plan:
- Unmapped load vaddr=0xA0001234 → next cycle resp_valid=1, paddr=0x00001234, cached=0, dataMiss=0, dataValid=1, dataDirty=1, jtlb_req=0.
- Mapped store vaddr=0x00403004, asid=5, empty uTLB; JTLB acks after 3 cycles with found=1, pfn1=0x12345, flags1={3'b011,1,1} → jtlb_vpn2=0x00201; resp paddr=0x12345004, dataValid=1, dataDirty=1, cached=1; repeat access hits with 1-cycle latency.
- JTLB ack with found=0 for vaddr=0x7FFF0000 load → exactly one resp_valid with dataMiss=1, dataValid=0; FSM returns to IDLE.
- Fill 5 distinct vpn2 into 4 entries → 5th overwrites entry 0; first vpn2 re-access refills, others hit.
- ASID mismatch: entry g=0 asid=3, lookup asid=4 → refill; same with g=1 → hit.
- flush asserted during REFILL → first ack ignored, jtlb_req re-asserted next cycle; second ack writes; rst mid-REFILL drops jtlb_req and busy asynchronously.
